// File: rtl/waveform_sequencer.sv
// Waveform sequencer: a programmable prescaler advances a step index through
// STEPS samples per period and produces a registered 8-bit amplitude for the
// DAC stage (square, sawtooth, triangle or DC midscale).
module waveform_sequencer #(
   parameter int STEPS   = 200,
   parameter int RST_DIV = 500
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [27:0] frequency_selection,
   input  logic [1:0]  wave_sel,
   output logic        sample_tick,
   output logic [7:0]  step,
   output logic        cycle_done,
   output logic [7:0]  sample
);

   localparam logic [7:0]  LAST_STEP = 8'(STEPS - 1);
   localparam logic [7:0]  HALF_STEP = 8'(STEPS / 2);
   localparam logic [27:0] RST_DIVW  = 28'(RST_DIV);

   logic [27:0] div_reg;
   logic [27:0] div_cnt;
   logic        terminal;

   // A zero divisor would never reach terminal count; treat it as 1.
   function automatic logic [27:0] clamp_divisor(input logic [27:0] f);
      return (f == 28'd0) ? 28'd1 : f;
   endfunction

   // Amplitude for a given step index and waveform selection.
   function automatic logic [7:0] wave_lookup(input logic [7:0] s, input logic [1:0] sel);
      logic [8:0] dbl;
      logic [7:0] res;
      res = 8'd0;
      dbl = 9'd0;
      case (sel)
         2'd0: res = (s < HALF_STEP) ? 8'd255 : 8'd0;
         2'd1: res = s;
         2'd2: begin
            if (s < HALF_STEP) dbl = {s, 1'b0};
            else               dbl = {LAST_STEP - s, 1'b0};
            res = dbl[7:0];
         end
         default: res = 8'd128;
      endcase
      return res;
   endfunction

   // Anything at or past div_reg-1 counts as terminal so a stray count can
   // never run away; div_reg is never below 1, so the subtraction is safe.
   assign terminal = (div_cnt >= div_reg - 28'd1);

   // Prescaler and divisor: divisor only reloads on a step boundary so a
   // mid-step frequency change cannot stretch or shorten the current step.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt <= 28'd0;
         div_reg <= RST_DIVW;
      end else if (enable) begin
         if (terminal) begin
            div_cnt <= 28'd0;
            div_reg <= clamp_divisor(frequency_selection);
         end else begin
            div_cnt <= div_cnt + 28'd1;
         end
      end
   end

   // Step index with wrap, plus the one-cycle tick and period-done pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         step        <= 8'd0;
         sample_tick <= 1'b0;
         cycle_done  <= 1'b0;
      end else if (enable && terminal) begin
         step        <= (step >= LAST_STEP) ? 8'd0 : step + 8'd1;
         sample_tick <= 1'b1;
         cycle_done  <= (step >= LAST_STEP);
      end else begin
         sample_tick <= 1'b0;
         cycle_done  <= 1'b0;
      end
   end

   // Output amplitude: follows the step value present before the edge, so it
   // trails step by one clock; wave_sel changes land on the next update.
   always_ff @(posedge clk) begin
      if (reset) begin
         sample <= 8'd0;
      end else if (enable) begin
         sample <= wave_lookup(step, wave_sel);
      end
   end

endmodule

// File: tb/tb_waveform_sequencer.sv
// Bench for waveform_sequencer: directed step-timing scenarios, a table of
// waveform amplitudes, and randomized traffic against a behavioural model.
module tb_waveform_sequencer;

   localparam int STEPS   = 200;
   localparam int RST_DIV = 500;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [27:0] frequency_selection;
   logic [1:0]  wave_sel;
   logic        sample_tick;
   logic [7:0]  step;
   logic        cycle_done;
   logic [7:0]  sample;

   int checks = 0;
   int errors = 0;

   // Behavioural model: elapsed clocks within the current step vs its length.
   bit m_valid = 0;
   int m_step, m_elapsed, m_len, m_sample;
   bit m_tick, m_done;

   waveform_sequencer #(.STEPS(STEPS), .RST_DIV(RST_DIV)) dut (
      .clk                 (clk),
      .reset               (reset),
      .enable              (enable),
      .frequency_selection (frequency_selection),
      .wave_sel            (wave_sel),
      .sample_tick         (sample_tick),
      .step                (step),
      .cycle_done          (cycle_done),
      .sample              (sample)
   );

   always #5 clk = ~clk;

   typedef struct {
      int sel;
      int s;
      int exp;
   } wave_vec_t;

   function automatic int wave_ref(input int s, input int sel);
      case (sel)
         0:       return (s < STEPS / 2) ? 255 : 0;
         1:       return s % 256;
         2:       return (s < STEPS / 2) ? 2 * s : 2 * (STEPS - 1 - s);
         default: return 128;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_update();
      if (reset) begin
         m_valid   = 1;
         m_step    = 0;
         m_elapsed = 0;
         m_len     = RST_DIV;
         m_sample  = 0;
         m_tick    = 0;
         m_done    = 0;
      end else if (enable) begin
         m_sample  = wave_ref(m_step, int'(wave_sel));
         m_elapsed = m_elapsed + 1;
         m_tick    = 0;
         m_done    = 0;
         if (m_elapsed >= m_len) begin
            m_elapsed = 0;
            m_step    = (m_step + 1) % STEPS;
            m_tick    = 1;
            m_done    = (m_step == 0);
            m_len     = (frequency_selection == 0) ? 1 : int'(frequency_selection);
         end
      end else begin
         m_tick = 0;
         m_done = 0;
      end
   endtask

   // One clock: update the model on the edge, compare just after it.
   task automatic tick_clk();
      @(posedge clk);
      model_update();
      #1;
      if (m_valid) begin
         chk("sample_tick", int'(sample_tick), int'(m_tick));
         chk("cycle_done", int'(cycle_done), int'(m_done));
         chk("step", int'(step), m_step);
         chk("sample", int'(sample), m_sample);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick_clk();
   endtask

   // Clock until sample_tick shows; n is the number of edges taken.
   task automatic wait_tick(input int bound, output int n);
      n = 0;
      do begin
         tick_clk();
         n++;
      end while (!sample_tick && n < bound);
      if (!sample_tick) begin
         errors++;
         $display("FAIL wait_tick: no sample_tick within %0d cycles", bound);
      end
   endtask

   wave_vec_t wv[13];

   initial begin
      int n, ticks, dones, held_step, held_sample, k;

      wv[0]  = '{0, 0, 255};   wv[1]  = '{0, 99, 255};  wv[2]  = '{0, 100, 0};
      wv[3]  = '{0, 199, 0};   wv[4]  = '{1, 0, 0};     wv[5]  = '{1, 137, 137};
      wv[6]  = '{1, 199, 199}; wv[7]  = '{2, 0, 0};     wv[8]  = '{2, 50, 100};
      wv[9]  = '{2, 99, 198};  wv[10] = '{2, 100, 198}; wv[11] = '{2, 199, 0};
      wv[12] = '{3, 77, 128};

      reset = 1; enable = 0; frequency_selection = 28'd123; wave_sel = 2'd1;
      run(2);
      chk("rst_tick", int'(sample_tick), 0);
      chk("rst_done", int'(cycle_done), 0);
      chk("rst_step", int'(step), 0);
      chk("rst_sample", int'(sample), 0);

      // First step uses the reset divisor even though the input differs.
      reset = 0; enable = 1;
      run(200);
      frequency_selection = 28'd500;
      wait_tick(1000, n);
      chk("first_step_len", n + 200, RST_DIV);
      chk("first_step_idx", int'(step), 1);
      wait_tick(1000, n);
      chk("step_len_500a", n, 500);
      wait_tick(1000, n);
      chk("step_len_500b", n, 500);

      // Mid-step change to 250: current step keeps 500, the next is 250.
      run(100);
      frequency_selection = 28'd250;
      wait_tick(1000, n);
      chk("midchange_cur", n + 100, 500);
      frequency_selection = 28'd500;
      wait_tick(1000, n);
      chk("midchange_next", n, 250);

      // Pause at count 123 for 37 cycles with divisor 500.
      run(123);
      enable = 0;
      held_step = int'(step);
      held_sample = int'(sample);
      ticks = 0;
      for (int i = 0; i < 37; i++) begin
         tick_clk();
         ticks += int'(sample_tick) + int'(cycle_done);
      end
      chk("pause_ticks", ticks, 0);
      chk("pause_step", int'(step), held_step);
      chk("pause_sample", int'(sample), held_sample);
      enable = 1;
      wait_tick(1000, n);
      chk("resume_len", n - 1, 376);

      // Divisor 0 clamps to 1 after the next reload: tick every cycle.
      frequency_selection = 28'd0;
      wait_tick(1000, n);
      ticks = 0; dones = 0;
      for (int i = 0; i < STEPS; i++) begin
         tick_clk();
         ticks += int'(sample_tick);
         dones += int'(cycle_done);
      end
      chk("fast_ticks", ticks, STEPS);
      chk("fast_dones", dones, 1);
      frequency_selection = 28'd1;
      run(5);
      chk("div1_tick", int'(sample_tick), 1);

      // Waveform amplitude table at one step per clock.
      foreach (wv[i]) begin
         wave_sel = 2'(wv[i].sel);
         k = 0;
         while (m_step != wv[i].s && k < 400) begin
            tick_clk();
            k++;
         end
         tick_clk();
         chk($sformatf("wave_sel%0d_step%0d", wv[i].sel, wv[i].s), int'(sample), wv[i].exp);
      end

      // Reset coinciding with terminal count at step 199.
      k = 0;
      while (m_step != STEPS - 1 && k < 400) begin
         tick_clk();
         k++;
      end
      reset = 1;
      tick_clk();
      chk("rst_tc_tick", int'(sample_tick), 0);
      chk("rst_tc_done", int'(cycle_done), 0);
      chk("rst_tc_step", int'(step), 0);
      reset = 0;
      wait_tick(1000, n);
      chk("rst_tc_divreg", n, RST_DIV);

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         enable = ($urandom_range(9) != 0);
         reset = ($urandom_range(499) == 0);
         wave_sel = 2'($urandom_range(3));
         frequency_selection = 28'($urandom_range(6));
         tick_clk();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
